bus_op_sched: RTL and testbench

- Schedules 68K bus operations for the bus transfer engine on behalf of two requesters: the Pi host register port (host) and an auxiliary internal agent (aux).
- Writes are posted into a shared FIFO so the requester is released immediately.
- Reads are held until all earlier writes have retired, then issued, and the data is returned to the owner.
- Sits between the Pi-side register logic and the S0–S7 bus state machine; drives its op request and consumes its completion.

---
 rtl/bus_op_sched.sv | 168 ++++++++++++++++
 tb/tb_bus_op_sched.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_op_sched.sv
// Bus operation scheduler: arbitrates host/aux requests, posts writes through a FIFO,
// and holds a single read until all earlier writes have retired on the 68K bus.
module bus_op_sched #(
  parameter int DEPTH = 4,
  parameter int LW    = 3
) (
  input  logic          M68K_CLK,
  input  logic          oor,
  input  logic          host_valid,
  output logic          host_ready,
  input  logic [22:0]   host_a,
  input  logic          host_a0,
  input  logic          host_sz,
  input  logic          host_rw,
  input  logic [15:0]   host_wdata,
  output logic [15:0]   host_rdata,
  output logic          host_rvalid,
  input  logic          aux_valid,
  output logic          aux_ready,
  input  logic [22:0]   aux_a,
  input  logic          aux_a0,
  input  logic          aux_sz,
  input  logic          aux_rw,
  input  logic [15:0]   aux_wdata,
  output logic [15:0]   aux_rdata,
  output logic          aux_rvalid,
  output logic          bus_req,
  output logic [22:0]   bus_a,
  output logic          bus_a0,
  output logic          bus_sz,
  output logic          bus_rw,
  output logic [15:0]   bus_dout,
  input  logic [15:0]   bus_din,
  input  logic          bus_done,
  output logic          busy,
  output logic [LW-1:0] fifo_level
);
  localparam int PW = $clog2(DEPTH);
  localparam int EW = 41;  // {a, a0, sz, wdata}

  typedef enum logic [1:0] {IDLE, WR_BUS, RD_BUS} state_t;

  state_t                   state_q, state_d;
  logic [DEPTH-1:0][EW-1:0] mem_q;
  logic [PW-1:0]            wp_q, rp_q;
  logic [LW-1:0]            level_q;
  logic                     rd_pend_q, rd_own_q, last_aux_q;
  logic [24:0]              hold_q;
  logic                     req_q, rw_q, a0_q, sz_q;
  logic [22:0]              a_q;
  logic [15:0]              dout_q, hrdata_q, ardata_q;
  logic                     hrvalid_q, arvalid_q;

  logic          full, h_el, a_el, gnt_h, gnt_a, xfer, push, rd_acc, req_rw;
  logic          issue_wr, issue_rd, fin;
  logic [EW-1:0] req_ent;

  // Full is judged on the registered level, so a same-cycle pop never frees a slot.
  assign full   = (level_q == LW'(DEPTH));
  assign h_el   = host_valid & ~rd_pend_q & (host_rw | ~full);
  assign a_el   = aux_valid  & ~rd_pend_q & (aux_rw  | ~full);
  assign gnt_h  = h_el & (~a_el | last_aux_q);
  assign gnt_a  = a_el & (~h_el | ~last_aux_q);
  assign xfer   = gnt_h | gnt_a;
  assign req_rw = gnt_a ? aux_rw : host_rw;
  assign req_ent = gnt_a ? {aux_a, aux_a0, aux_sz, aux_wdata}
                         : {host_a, host_a0, host_sz, host_wdata};
  assign push   = xfer & ~req_rw;
  assign rd_acc = xfer & req_rw;

  always_comb begin
    state_d  = state_q;
    issue_wr = 1'b0;
    issue_rd = 1'b0;
    fin      = 1'b0;
    case (state_q)
      IDLE: begin
        // Queued writes always drain before the held read, keeping program order.
        if (level_q != '0) begin
          issue_wr = 1'b1;
          state_d  = WR_BUS;
        end else if (rd_pend_q) begin
          issue_rd = 1'b1;
          state_d  = RD_BUS;
        end
      end
      WR_BUS, RD_BUS: begin
        if (bus_done) begin
          fin     = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge M68K_CLK) begin
    if (push) mem_q[wp_q] <= req_ent;
  end

  always_ff @(posedge M68K_CLK or posedge oor) begin
    if (oor) begin
      state_q    <= IDLE;
      wp_q       <= '0;
      rp_q       <= '0;
      level_q    <= '0;
      rd_pend_q  <= 1'b0;
      rd_own_q   <= 1'b0;
      last_aux_q <= 1'b1;
      hold_q     <= '0;
      req_q      <= 1'b0;
      rw_q       <= 1'b1;
      a_q        <= '0;
      a0_q       <= 1'b0;
      sz_q       <= 1'b0;
      dout_q     <= '0;
      hrdata_q   <= '0;
      ardata_q   <= '0;
      hrvalid_q  <= 1'b0;
      arvalid_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_q + LW'(push) - LW'(issue_wr);
      if (push)     wp_q <= wp_q + 1'b1;
      if (issue_wr) rp_q <= rp_q + 1'b1;
      if (xfer)     last_aux_q <= gnt_a;
      if (rd_acc) begin
        rd_pend_q <= 1'b1;
        rd_own_q  <= gnt_a;
        hold_q    <= req_ent[EW-1:16];
      end else if (fin && state_q == RD_BUS) begin
        rd_pend_q <= 1'b0;
      end
      if (issue_wr) begin
        {a_q, a0_q, sz_q, dout_q} <= mem_q[rp_q];
        rw_q  <= 1'b0;
        req_q <= 1'b1;
      end else if (issue_rd) begin
        {a_q, a0_q, sz_q} <= hold_q;
        rw_q  <= 1'b1;
        req_q <= 1'b1;
      end else if (fin) begin
        req_q <= 1'b0;
      end
      hrvalid_q <= fin && state_q == RD_BUS && !rd_own_q;
      arvalid_q <= fin && state_q == RD_BUS &&  rd_own_q;
      if (fin && state_q == RD_BUS) begin
        if (rd_own_q) ardata_q <= bus_din;
        else          hrdata_q <= bus_din;
      end
    end
  end

  assign host_ready  = gnt_h;
  assign aux_ready   = gnt_a;
  assign host_rdata  = hrdata_q;
  assign aux_rdata   = ardata_q;
  assign host_rvalid = hrvalid_q;
  assign aux_rvalid  = arvalid_q;
  assign bus_req     = req_q;
  assign bus_a       = a_q;
  assign bus_a0      = a0_q;
  assign bus_sz      = sz_q;
  assign bus_rw      = rw_q;
  assign bus_dout    = dout_q;
  assign fifo_level  = level_q;
  assign busy        = (state_q != IDLE) | (level_q != '0) | rd_pend_q;
endmodule

// File: tb/tb_bus_op_sched.sv
// Directed bench for bus_op_sched: scoreboard of expected bus ops, served by a
// small bus-engine model that compares each issued op and returns read data.
module tb_bus_op_sched;
  logic        clk = 1'b0;
  logic        oor;
  logic        host_valid, host_ready, host_a0, host_sz, host_rw, host_rvalid;
  logic [22:0] host_a;
  logic [15:0] host_wdata, host_rdata;
  logic        aux_valid, aux_ready, aux_a0, aux_sz, aux_rw, aux_rvalid;
  logic [22:0] aux_a;
  logic [15:0] aux_wdata, aux_rdata;
  logic        bus_req, bus_a0, bus_sz, bus_rw, bus_done, busy;
  logic [22:0] bus_a;
  logic [15:0] bus_dout, bus_din;
  logic [2:0]  fifo_level;

  typedef struct {
    logic        rw;
    logic [22:0] a;
    logic        a0;
    logic        sz;
    logic [15:0] d;
    logic        own;
  } op_t;

  op_t sb[$];
  int  npass = 0, nfail = 0, ntot = 0;

  always #5 clk = ~clk;

  bus_op_sched #(.DEPTH(4), .LW(3)) dut (
    .M68K_CLK(clk), .oor(oor),
    .host_valid(host_valid), .host_ready(host_ready), .host_a(host_a), .host_a0(host_a0),
    .host_sz(host_sz), .host_rw(host_rw), .host_wdata(host_wdata), .host_rdata(host_rdata),
    .host_rvalid(host_rvalid),
    .aux_valid(aux_valid), .aux_ready(aux_ready), .aux_a(aux_a), .aux_a0(aux_a0),
    .aux_sz(aux_sz), .aux_rw(aux_rw), .aux_wdata(aux_wdata), .aux_rdata(aux_rdata),
    .aux_rvalid(aux_rvalid),
    .bus_req(bus_req), .bus_a(bus_a), .bus_a0(bus_a0), .bus_sz(bus_sz), .bus_rw(bus_rw),
    .bus_dout(bus_dout), .bus_din(bus_din), .bus_done(bus_done),
    .busy(busy), .fifo_level(fifo_level)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_drv(input logic rw, input logic [22:0] a, input logic a0,
                          input logic sz, input logic [15:0] d);
    host_valid = 1'b1; host_rw = rw; host_a = a; host_a0 = a0; host_sz = sz; host_wdata = d;
  endtask

  task automatic aux_drv(input logic rw, input logic [22:0] a, input logic a0,
                         input logic sz, input logic [15:0] d);
    aux_valid = 1'b1; aux_rw = rw; aux_a = a; aux_a0 = a0; aux_sz = sz; aux_wdata = d;
  endtask

  task automatic expect_op(input logic rw, input logic [22:0] a, input logic a0,
                           input logic sz, input logic [15:0] d, input logic own);
    op_t e;
    e.rw = rw; e.a = a; e.a0 = a0; e.sz = sz; e.d = d; e.own = own;
    sb.push_back(e);
  endtask

  // Engine model: wait for the op, compare against the scoreboard head, hold it
  // for 'hold' cycles, pulse bus_done, then check the release and any read return.
  // Returns in the cycle after bus_done.
  task automatic serve(input int hold);
    op_t e;
    int  n = 0;
    while (!bus_req && n < 64) begin
      tick();
      n++;
    end
    chk("bus_req_wait", bus_req, 1);
    chk("sb_has_entry", sb.size() != 0, 1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    chk("bus_rw", bus_rw, e.rw);
    chk("bus_a", bus_a, e.a);
    chk("bus_a0", bus_a0, e.a0);
    chk("bus_sz", bus_sz, e.sz);
    if (!e.rw) chk("bus_dout", bus_dout, e.d);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("bus_req_hold", bus_req, 1);
      chk("bus_a_stable", bus_a, e.a);
    end
    bus_done = 1'b1;
    bus_din  = e.rw ? e.d : 16'hDEAD;
    tick();
    bus_done = 1'b0;
    bus_din  = 16'h0;
    chk("bus_req_drop", bus_req, 0);
    chk("host_rvalid", host_rvalid, e.rw & ~e.own);
    chk("aux_rvalid", aux_rvalid, e.rw & e.own);
    if (e.rw) chk("rdata", e.own ? aux_rdata : host_rdata, e.d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    oor = 1'b1;
    host_valid = 0; host_rw = 0; host_a = '0; host_a0 = 0; host_sz = 0; host_wdata = '0;
    aux_valid = 0; aux_rw = 0; aux_a = '0; aux_a0 = 0; aux_sz = 0; aux_wdata = '0;
    bus_done = 0; bus_din = '0;
    tick(); tick();
    chk("rst_bus_req", bus_req, 0);
    chk("rst_bus_rw", bus_rw, 1);
    chk("rst_level", fifo_level, 0);
    chk("rst_busy", busy, 0);
    chk("rst_host_rdata", host_rdata, 0);
    chk("rst_aux_rvalid", aux_rvalid, 0);
    oor = 1'b0;
    tick();

    // Round-robin: host wins first after reset, then alternation.
    for (int i = 0; i < 4; i++) begin
      host_drv(1'b0, 23'(23'h100 + i), 1'b0, 1'b0, 16'(16'hA000 + i));
      aux_drv(1'b0, 23'(23'h200 + i), 1'b0, 1'b0, 16'(16'hB000 + i));
      #1;
      chk("rr_host_ready", host_ready, (i % 2) == 0);
      chk("rr_aux_ready", aux_ready, (i % 2) == 1);
      if (i % 2 == 0) expect_op(1'b0, 23'(23'h100 + i), 1'b0, 1'b0, 16'(16'hA000 + i), 1'b0);
      else            expect_op(1'b0, 23'(23'h200 + i), 1'b0, 1'b0, 16'(16'hB000 + i), 1'b1);
      tick();
    end
    host_valid = 0; aux_valid = 0;
    for (int i = 0; i < 4; i++) serve(0);
    tick();

    // Single host write: 2-cycle latency to bus_req, address is A[23:1].
    host_drv(1'b0, 23'h6FF8C0, 1'b0, 1'b0, 16'h0F00);
    #1;
    chk("w1_ready", host_ready, 1);
    expect_op(1'b0, 23'h6FF8C0, 1'b0, 1'b0, 16'h0F00, 1'b0);
    tick();
    host_valid = 0;
    chk("w1_req_c1", bus_req, 0);
    chk("w1_level", fifo_level, 1);
    tick();
    chk("w1_req_c2", bus_req, 1);
    serve(2);
    chk("w1_busy_end", busy, 0);
    tick();

    // Burst of writes with bus_done withheld: FIFO fills, next write stalls.
    for (int i = 0; i < 5; i++) begin
      host_drv(1'b0, 23'(23'h300 + i), 1'b0, 1'b0, 16'(16'hC000 + i));
      #1;
      chk("burst_ready", host_ready, 1);
      expect_op(1'b0, 23'(23'h300 + i), 1'b0, 1'b0, 16'(16'hC000 + i), 1'b0);
      tick();
    end
    chk("burst_level_full", fifo_level, 4);
    host_drv(1'b0, 23'h305, 1'b0, 1'b0, 16'hC005);
    #1;
    chk("burst_full_block", host_ready, 0);
    serve(1);
    chk("burst_pop_cycle_block", host_ready, 0);
    tick();
    chk("burst_after_pop", host_ready, 1);
    expect_op(1'b0, 23'h305, 1'b0, 1'b0, 16'hC005, 1'b0);
    tick();
    host_valid = 0;
    for (int i = 0; i < 5; i++) serve(0);
    chk("burst_level_end", fifo_level, 0);
    chk("burst_busy_end", busy, 0);
    tick();

    // Two writes then an aux byte read; the read waits behind both writes.
    host_drv(1'b0, 23'h000400, 1'b0, 1'b0, 16'h1111);
    expect_op(1'b0, 23'h000400, 1'b0, 1'b0, 16'h1111, 1'b0);
    tick();
    host_drv(1'b0, 23'h000401, 1'b0, 1'b0, 16'h2222);
    expect_op(1'b0, 23'h000401, 1'b0, 1'b0, 16'h2222, 1'b0);
    tick();
    host_valid = 0;
    aux_drv(1'b1, 23'h5FF000, 1'b1, 1'b1, 16'h0);
    #1;
    chk("rd_aux_ready", aux_ready, 1);
    expect_op(1'b1, 23'h5FF000, 1'b1, 1'b1, 16'h00FF, 1'b1);
    tick();
    aux_valid = 0;
    host_drv(1'b0, 23'h000402, 1'b0, 1'b0, 16'h3333);
    #1;
    chk("rd_pend_block", host_ready, 0);
    serve(0);
    chk("rd_pend_block_w1", host_ready, 0);
    serve(0);
    chk("rd_pend_block_w2", host_ready, 0);
    serve(1);
    chk("rd_release", host_ready, 1);
    expect_op(1'b0, 23'h000402, 1'b0, 1'b0, 16'h3333, 1'b0);
    tick();
    host_valid = 0;
    chk("rd_pulse_end", aux_rvalid, 0);
    chk("rd_aux_hold", aux_rdata, 16'h00FF);
    serve(0);
    tick();

    // Host read; aux read data must be unaffected.
    host_drv(1'b1, 23'h012345, 1'b0, 1'b0, 16'h0);
    #1;
    chk("hrd_ready", host_ready, 1);
    expect_op(1'b1, 23'h012345, 1'b0, 1'b0, 16'h1234, 1'b0);
    tick();
    host_valid = 0;
    serve(0);
    chk("hrd_aux_hold", aux_rdata, 16'h00FF);
    tick();
    chk("hrd_pulse_end", host_rvalid, 0);

    // Reset in the middle of a write with three more queued.
    for (int i = 0; i < 4; i++) begin
      host_drv(1'b0, 23'(23'h500 + i), 1'b0, 1'b0, 16'(16'hD000 + i));
      tick();
    end
    host_valid = 0;
    chk("mid_level", fifo_level, 3);
    chk("mid_req", bus_req, 1);
    oor = 1'b1;
    #1;
    chk("mid_rst_req", bus_req, 0);
    chk("mid_rst_level", fifo_level, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_hrdata", host_rdata, 0);
    sb.delete();
    tick();
    oor = 1'b0;
    tick();
    chk("post_rst_hrvalid", host_rvalid, 0);
    chk("post_rst_req", bus_req, 0);
    host_drv(1'b0, 23'h000777, 1'b1, 1'b1, 16'h00AB);
    #1;
    chk("post_rst_ready", host_ready, 1);
    expect_op(1'b0, 23'h000777, 1'b1, 1'b1, 16'h00AB, 1'b0);
    tick();
    host_valid = 0;
    serve(0);
    chk("post_rst_busy", busy, 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
